// File: rtl/tcm_loader_if.sv
// Stream and TCM write bus of the program loader.
//   s_valid/s_ready/s_data/s_last : byte stream into the loader
//   tcm_addr/tcm_wdata            : shared word address and data for both TCMs
//   itcm_we/dtcm_we               : per-SRAM write strobes
// master: the loader side; slave: the stream source and the SRAM side.
interface tcm_loader_if #(
  parameter int unsigned AW = 12
) ();
  logic          s_valid;
  logic          s_ready;
  logic [7:0]    s_data;
  logic          s_last;
  logic [AW-1:0] tcm_addr;
  logic [31:0]   tcm_wdata;
  logic          itcm_we;
  logic          dtcm_we;

  modport master (
    input  s_valid, s_data, s_last,
    output s_ready, tcm_addr, tcm_wdata, itcm_we, dtcm_we
  );

  modport slave (
    output s_valid, s_data, s_last,
    input  s_ready, tcm_addr, tcm_wdata, itcm_we, dtcm_we
  );
endinterface

// File: rtl/tcm_loader.sv
// Program loader in front of ITCM/DTCM: packs a byte stream little-endian
// into 32-bit words, writes them from word 0 upward (optionally mirrored into
// DTCM), optionally zero-fills the rest of the array, and keeps the core in
// reset until loading is complete.
//   clk, rst      : clock, asynchronous active-high reset
//   start_i       : begin a load (honoured only in IDLE/DONE)
//   bus           : byte stream in, TCM write port out (tcm_loader_if.master)
//   cpu_rst_n_o   : core reset, released once DONE is reached
//   pc_rtvec_o    : constant core reset vector
//   busy_o/done_o : loading in progress / load finished
//   ovf_err_o     : image longer than the array; sticky until the next start
module tcm_loader #(
  parameter int unsigned AW        = 12,
  parameter logic [31:0] RST_VEC   = 32'h0000_0080,
  parameter bit          MIRROR    = 1'b1,
  parameter bit          FILL_ZERO = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  tcm_loader_if.master bus,
  output logic        cpu_rst_n_o,
  output logic [31:0] pc_rtvec_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        ovf_err_o
);

  localparam logic [AW-1:0] LAST_IDX = {AW{1'b1}};

  typedef enum logic [1:0] {IDLE, LOAD, FILL, DONE} state_e;

  state_e        state_q, state_d;
  logic [1:0]    byte_cnt_q, byte_cnt_d;
  logic [AW-1:0] word_idx_q, word_idx_d;
  logic [31:0]   asm_q, asm_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          itcm_we_q, itcm_we_d;
  logic          dtcm_we_q, dtcm_we_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          ovf_q, ovf_d;
  logic          cpu_rst_n_q, cpu_rst_n_d;
  logic          s_ready_c;
  logic          accept_c;
  logic [31:0]   lane_word_c;

  assign s_ready_c   = (state_q == LOAD);
  assign accept_c    = s_ready_c && bus.s_valid;
  // Current byte merged into its lane; lanes above it are still zero.
  assign lane_word_c = asm_q | (32'(bus.s_data) << {byte_cnt_q, 3'b000});

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      byte_cnt_q  <= '0;
      word_idx_q  <= '0;
      asm_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      itcm_we_q   <= 1'b0;
      dtcm_we_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
      cpu_rst_n_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      word_idx_q  <= word_idx_d;
      asm_q       <= asm_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      itcm_we_q   <= itcm_we_d;
      dtcm_we_q   <= dtcm_we_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ovf_q       <= ovf_d;
      cpu_rst_n_q <= cpu_rst_n_d;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    word_idx_d = word_idx_q;
    asm_d      = asm_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    itcm_we_d  = 1'b0;
    dtcm_we_d  = 1'b0;
    ovf_d      = ovf_q;

    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d    = LOAD;
          word_idx_d = '0;
          byte_cnt_d = '0;
          asm_d      = '0;
          ovf_d      = 1'b0;
        end
      end
      LOAD: begin
        if (accept_c) begin
          if (byte_cnt_q == 2'd3 || bus.s_last) begin
            addr_d     = word_idx_q;
            wdata_d    = lane_word_c;
            itcm_we_d  = 1'b1;
            dtcm_we_d  = MIRROR;
            word_idx_d = word_idx_q + AW'(1);
            asm_d      = '0;
            byte_cnt_d = '0;
            if (bus.s_last) begin
              state_d = (FILL_ZERO && word_idx_q != LAST_IDX) ? FILL : DONE;
            end else if (word_idx_q == LAST_IDX) begin
              // Array full but the image goes on: stop and flag it.
              state_d = DONE;
              ovf_d   = 1'b1;
            end
          end else begin
            asm_d      = lane_word_c;
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end
      end
      FILL: begin
        addr_d     = word_idx_q;
        wdata_d    = '0;
        itcm_we_d  = 1'b1;
        dtcm_we_d  = MIRROR;
        word_idx_d = word_idx_q + AW'(1);
        if (word_idx_q == LAST_IDX) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d      = (state_d == LOAD) || (state_d == FILL);
    // Set one cycle after entering DONE, so the core leaves reset only after
    // the last write strobe has been seen by the SRAMs.
    done_d      = (state_q == DONE) && (state_d == DONE);
    cpu_rst_n_d = done_d;
  end

  assign bus.s_ready   = s_ready_c;
  assign bus.tcm_addr  = addr_q;
  assign bus.tcm_wdata = wdata_q;
  assign bus.itcm_we   = itcm_we_q;
  assign bus.dtcm_we   = dtcm_we_q;
  assign cpu_rst_n_o   = cpu_rst_n_q;
  assign pc_rtvec_o    = RST_VEC;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign ovf_err_o     = ovf_q;

endmodule

// File: tb/tb_tcm_loader.sv
// Bench for tcm_loader: instance A (16 words, mirrored, zero fill) and
// instance B (4 words, no mirror, no fill) share one stimulus driver selected
// by sel. Expected writes are queued when bytes are accepted and popped by
// per-instance monitors when the write strobes appear.
module tb_tcm_loader;

  localparam int unsigned DEPTH_A = 16;

  logic clk = 1'b0;
  logic rst;
  logic sel;
  logic drv_start, drv_valid, drv_last;
  logic [7:0] drv_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  tcm_loader_if #(.AW(4)) if_a ();
  tcm_loader_if #(.AW(2)) if_b ();

  logic        rn_a, busy_a, done_a, ovf_a, start_a;
  logic        rn_b, busy_b, done_b, ovf_b, start_b;
  logic [31:0] vec_a, vec_b;
  logic        rdy;

  assign start_a        = drv_start && !sel;
  assign start_b        = drv_start && sel;
  assign if_a.s_valid   = drv_valid && !sel;
  assign if_b.s_valid   = drv_valid && sel;
  assign if_a.s_data    = drv_data;
  assign if_b.s_data    = drv_data;
  assign if_a.s_last    = drv_last;
  assign if_b.s_last    = drv_last;
  assign rdy            = sel ? if_b.s_ready : if_a.s_ready;

  tcm_loader #(.AW(4), .RST_VEC(32'h0000_0080), .MIRROR(1'b1), .FILL_ZERO(1'b1)) dut_a (
    .clk(clk), .rst(rst), .start_i(start_a), .bus(if_a.master),
    .cpu_rst_n_o(rn_a), .pc_rtvec_o(vec_a), .busy_o(busy_a), .done_o(done_a),
    .ovf_err_o(ovf_a)
  );

  tcm_loader #(.AW(2), .RST_VEC(32'h0000_0080), .MIRROR(1'b0), .FILL_ZERO(1'b0)) dut_b (
    .clk(clk), .rst(rst), .start_i(start_b), .bus(if_b.master),
    .cpu_rst_n_o(rn_b), .pc_rtvec_o(vec_b), .busy_o(busy_b), .done_o(done_b),
    .ovf_err_o(ovf_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard state
  logic [63:0] q_a[$];
  logic [63:0] q_b[$];
  logic [31:0] m_asm;
  int          m_cnt, m_idx;
  int          wr_a = 0, wr_b = 0;
  int          last_we_a = 0, rise_a = 0;
  logic        prev_rn_a = 1'b0;
  logic        b_dtcm_seen = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h exp 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor A: write contents, DTCM mirror, cpu_rst_n release timing.
  always @(negedge clk) begin
    logic [63:0] e;
    if (if_a.itcm_we || if_a.dtcm_we)
      check_eq("a_mirror", 64'(if_a.dtcm_we), 64'(if_a.itcm_we));
    if (if_a.itcm_we) begin
      wr_a++;
      last_we_a = cyc;
      if (q_a.size() == 0) begin
        check_eq("a_unexpected_wr", 64'(q_a.size()), 64'd1);
      end else begin
        e = q_a.pop_front();
        check_eq("a_addr", 64'(if_a.tcm_addr), 64'(e[63:32]));
        check_eq("a_data", 64'(if_a.tcm_wdata), 64'(e[31:0]));
      end
    end
    if (rn_a && !prev_rn_a) rise_a = cyc;
    prev_rn_a = rn_a;
  end

  // Monitor B: write contents; DTCM strobe must never fire.
  always @(negedge clk) begin
    logic [63:0] e;
    if (if_b.dtcm_we) b_dtcm_seen = 1'b1;
    if (if_b.itcm_we) begin
      wr_b++;
      if (q_b.size() == 0) begin
        check_eq("b_unexpected_wr", 64'(q_b.size()), 64'd1);
      end else begin
        e = q_b.pop_front();
        check_eq("b_addr", 64'(if_b.tcm_addr), 64'(e[63:32]));
        check_eq("b_data", 64'(if_b.tcm_wdata), 64'(e[31:0]));
      end
    end
  end

  task automatic push_exp(input int idx, input logic [31:0] d);
    if (sel) q_b.push_back({32'(idx), d});
    else     q_a.push_back({32'(idx), d});
  endtask

  // Reference packer: little-endian lanes, write on lane 3 or last byte.
  task automatic model_push(input logic [7:0] b, input bit last);
    m_asm = m_asm | (32'(b) << (8 * m_cnt));
    if (m_cnt == 3 || last) begin
      push_exp(m_idx, m_asm);
      m_idx++;
      m_asm = '0;
      m_cnt = 0;
      if (last && !sel) begin
        while (m_idx < int'(DEPTH_A)) begin
          push_exp(m_idx, 32'h0);
          m_idx++;
        end
      end
    end else begin
      m_cnt++;
    end
  endtask

  task automatic start_load();
    m_asm = '0; m_cnt = 0; m_idx = 0;
    drv_start = 1'b1;
    @(posedge clk); #1;
    drv_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit last, input int budget, output bit acc);
    int n;
    acc = 1'b0;
    n = 0;
    drv_valid = 1'b1; drv_data = b; drv_last = last;
    while (!acc && n < budget) begin
      @(negedge clk);
      acc = rdy;
      @(posedge clk); #1;
      n++;
    end
    drv_valid = 1'b0; drv_last = 1'b0;
    if (acc) model_push(b, last);
  endtask

  // Sends an image; gap inserts an idle cycle after each byte, with a start
  // pulse in the gap after the third byte.
  task automatic send_img(input logic [7:0] img[$], input bit last_end, input bit gap);
    bit acc;
    for (int i = 0; i < img.size(); i++) begin
      send_byte(img[i], last_end && (i == img.size() - 1), 50, acc);
      check_eq("byte_accept", 64'(acc), 64'd1);
      if (gap) begin
        drv_start = (i == 2);
        @(posedge clk); #1;
        drv_start = 1'b0;
      end
    end
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (n < budget && !(sel ? done_b : done_a)) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check_eq("done", 64'(sel ? done_b : done_a), 64'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [7:0] img[$];
    bit acc;
    int snap;
    rst = 1'b1; sel = 1'b0;
    drv_start = 1'b0; drv_valid = 1'b0; drv_last = 1'b0; drv_data = '0;
    m_asm = '0; m_cnt = 0; m_idx = 0;
    repeat (3) @(posedge clk); #1;

    // Reset values
    check_eq("rst_state_a", {if_a.s_ready, if_a.itcm_we, if_a.dtcm_we, busy_a, done_a, ovf_a, rn_a}, 64'd0);
    check_eq("rst_state_b", {if_b.s_ready, if_b.itcm_we, if_b.dtcm_we, busy_b, done_b, ovf_b, rn_b}, 64'd0);
    check_eq("rst_addr_a", 64'(if_a.tcm_addr), 64'd0);
    check_eq("rst_wdata_a", 64'(if_a.tcm_wdata), 64'd0);
    check_eq("rst_vec_a", 64'(vec_a), 64'h80);
    rst = 1'b0;
    @(posedge clk); #1;

    // Test 1: two-word image with zero fill on instance A
    sel = 1'b0; wr_a = 0;
    start_load();
    check_eq("t1_busy", 64'(busy_a), 64'd1);
    img = {8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    send_img(img, 1'b1, 1'b0);
    wait_done(100);
    check_eq("t1_writes", 64'(wr_a), 64'd16);
    check_eq("t1_q_empty", 64'(q_a.size()), 64'd0);
    check_eq("t1_rstn_rise", 64'(rise_a), 64'(last_we_a + 1));
    check_eq("t1_rstn", 64'(rn_a), 64'd1);
    check_eq("t1_vec", 64'(vec_a), 64'h80);
    check_eq("t1_busy_ovf", {busy_a, ovf_a}, 64'd0);

    // Test 2: five-byte image, partial second word (A mirrored, with fill)
    wr_a = 0;
    start_load();
    check_eq("t2_rstn_low", {rn_a, done_a}, 64'd0);
    img = {8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    send_img(img, 1'b1, 1'b0);
    wait_done(100);
    check_eq("t2_writes_a", 64'(wr_a), 64'd16);
    check_eq("t2_q_empty_a", 64'(q_a.size()), 64'd0);

    // Tests 2/3: same image on B: exactly two writes, no DTCM strobe
    sel = 1'b1; wr_b = 0;
    start_load();
    send_img(img, 1'b1, 1'b0);
    wait_done(50);
    check_eq("t3_writes_b", 64'(wr_b), 64'd2);
    check_eq("t3_dtcm_b", 64'(b_dtcm_seen), 64'd0);
    check_eq("t3_ovf_b", 64'(ovf_b), 64'd0);

    // Test 4: overflow on the 4-word instance, 20 bytes without s_last
    wr_b = 0;
    start_load();
    for (int i = 0; i < 20; i++) begin
      send_byte(8'(8'h40 + i), 1'b0, (i < 16) ? 50 : 3, acc);
      check_eq((i < 16) ? "t4_accept" : "t4_refuse", 64'(acc), (i < 16) ? 64'd1 : 64'd0);
    end
    wait_done(20);
    check_eq("t4_ovf", 64'(ovf_b), 64'd1);
    check_eq("t4_writes", 64'(wr_b), 64'd4);
    check_eq("t4_ready", 64'(if_b.s_ready), 64'd0);
    check_eq("t4_q_empty", 64'(q_b.size()), 64'd0);

    // ovf_err clears on start; s_last on lane 0
    start_load();
    check_eq("t4_ovf_clear", 64'(ovf_b), 64'd0);
    img = {8'h7E};
    send_img(img, 1'b1, 1'b0);
    wait_done(20);
    check_eq("t4_lane0_q", 64'(q_b.size()), 64'd0);

    // Test 5: reset during byte 6, then reload
    sel = 1'b0; wr_a = 0;
    start_load();
    img = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    send_img(img, 1'b0, 1'b0);
    drv_valid = 1'b1; drv_data = 8'h06;
    #2 rst = 1'b1;
    #1;
    check_eq("t5_strobes", {if_a.itcm_we, if_a.dtcm_we}, 64'd0);
    check_eq("t5_flags", {if_a.s_ready, busy_a, done_a, ovf_a, rn_a}, 64'd0);
    check_eq("t5_addr", 64'(if_a.tcm_addr), 64'd0);
    check_eq("t5_wdata", 64'(if_a.tcm_wdata), 64'd0);
    check_eq("t5_q_before_rst", 64'(q_a.size()), 64'd0);
    drv_valid = 1'b0;
    q_a.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    snap = wr_a;
    repeat (5) @(posedge clk); #1;
    check_eq("t5_no_strobe", 64'(wr_a), 64'(snap));
    start_load();
    img = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    send_img(img, 1'b1, 1'b0);
    wait_done(100);
    check_eq("t5_q_empty", 64'(q_a.size()), 64'd0);

    // Test 6: gapped stream with a start pulse during LOAD
    wr_a = 0;
    start_load();
    img = {8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18};
    send_img(img, 1'b1, 1'b1);
    wait_done(100);
    check_eq("t6_writes", 64'(wr_a), 64'd16);
    check_eq("t6_q_empty", 64'(q_a.size()), 64'd0);
    check_eq("dtcm_b_never", 64'(b_dtcm_seen), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

endmodule
